ws2812_bit_driver: RTL and testbench

- Downstream stage of the per-LED bit serializer. Accepts one code bit per handshake and drives the WS2812 single-wire data line with the matching high/low pulse.
- On request, drives the low latch/reset period that commits a frame.
- Timing is set entirely by cycle-count parameters. The block is the only driver of the LED pin.

---
 rtl/ws2812_pkg.sv | 30 +++
 rtl/ws2812_bit_driver.sv | 114 +++++++++++
 tb/tb_ws2812_bit_driver.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: driver state encoding, default 50 MHz timing and a sizing helper.
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_RES  = 2'd3
  } driver_state_e;

  localparam int unsigned T0H_CYC_DEF = 20;
  localparam int unsigned T0L_CYC_DEF = 40;
  localparam int unsigned T1H_CYC_DEF = 40;
  localparam int unsigned T1L_CYC_DEF = 20;
  localparam int unsigned RES_CYC_DEF = 15000;

  // Largest of the five timing counts; sizes the shared down-counter.
  function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/ws2812_bit_driver.sv
// WS2812 line driver: turns one handshaken code bit into a high/low pulse on dout,
// and drives the low latch period on request.
module ws2812_bit_driver
  import ws2812_pkg::*;
#(
  parameter int unsigned T0H_CYC = T0H_CYC_DEF,
  parameter int unsigned T0L_CYC = T0L_CYC_DEF,
  parameter int unsigned T1H_CYC = T1H_CYC_DEF,
  parameter int unsigned T1L_CYC = T1L_CYC_DEF,
  parameter int unsigned RES_CYC = RES_CYC_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic code_in,
  input  logic code_in_valid,
  input  logic latch_in,
  output logic ready_out,
  output logic dout,
  output logic res_done_out
);

  // Normally RES_CYC dominates; the max guards against unusual overrides.
  localparam int unsigned CNT_W = $clog2(max_cyc(T0H_CYC, T0L_CYC, T1H_CYC, T1L_CYC, RES_CYC) + 1);

  localparam logic [CNT_W-1:0] T0H_LD = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0] T0L_LD = CNT_W'(T0L_CYC - 1);
  localparam logic [CNT_W-1:0] T1H_LD = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0] T1L_LD = CNT_W'(T1L_CYC - 1);
  localparam logic [CNT_W-1:0] RES_LD = CNT_W'(RES_CYC - 1);

  if (T0H_CYC < 1 || T0L_CYC < 1 || T1H_CYC < 1 || T1L_CYC < 1 || RES_CYC < 1) begin : g_bad_timing
    $error("ws2812_bit_driver: all timing parameters must be >= 1");
  end

  driver_state_e    state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             bit_q, bit_d;
  logic             latch_pend_q, latch_pend_d;
  logic             dout_q, dout_d;
  logic             res_done_q, res_done_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      bit_q        <= 1'b0;
      latch_pend_q <= 1'b0;
      dout_q       <= 1'b0;
      res_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_q        <= bit_d;
      latch_pend_q <= latch_pend_d;
      dout_q       <= dout_d;
      res_done_q   <= res_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_d        = bit_q;
    latch_pend_d = latch_pend_q;
    res_done_d   = 1'b0;
    dout_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending latch blocks new bits until the reset period has been driven.
        if (latch_pend_q) begin
          state_d      = S_RES;
          timer_d      = RES_LD;
          latch_pend_d = 1'b0;
        end else if (code_in_valid) begin
          state_d = S_HIGH;
          bit_d   = code_in;
          timer_d = code_in ? T1H_LD : T0H_LD;
        end
      end
      S_HIGH: begin
        if (timer_q == '0) begin
          state_d = S_LOW;
          timer_d = bit_q ? T1L_LD : T0L_LD;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - CNT_W'(1);
      end
      S_RES: begin
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          res_done_d = 1'b1;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A latch request seen in any cycle (including during S_RES) is remembered.
    if (latch_in) latch_pend_d = 1'b1;

    dout_d = (state_d == S_HIGH);
  end

  assign ready_out    = (state_q == S_IDLE) && !latch_pend_q;
  assign dout         = dout_q;
  assign res_done_out = res_done_q;

endmodule

// File: tb/tb_ws2812_bit_driver.sv
// Self-checking bench for ws2812_bit_driver using short simulation timings.
module tb_ws2812_bit_driver;

  localparam int H0 = 2;
  localparam int L0 = 4;
  localparam int H1 = 4;
  localparam int L1 = 2;
  localparam int R  = 10;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic code_in;
  logic code_in_valid;
  logic latch_in;
  logic ready_out;
  logic dout;
  logic res_done_out;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  ws2812_bit_driver #(
    .T0H_CYC(H0), .T0L_CYC(L0), .T1H_CYC(H1), .T1L_CYC(L1), .RES_CYC(R)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .code_in      (code_in),
    .code_in_valid(code_in_valid),
    .latch_in     (latch_in),
    .ready_out    (ready_out),
    .dout         (dout),
    .res_done_out (res_done_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) step();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step();
    checks++;
    if (dout !== 1'b0) begin
      errors++; $display("FAIL reset_dout: got %b want 0", dout);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", ready_out);
    end
    checks++;
    if (res_done_out !== 1'b0) begin
      errors++; $display("FAIL reset_res_done: got %b want 0", res_done_out);
    end
  endtask

  // Sends one bit from an idle driver; spam keeps code_in_valid high while busy.
  // Expected: dout high for H samples after the accept edge, ready back after H+L.
  task automatic send_bit(input logic b, input logic spam, output int hi_cnt);
    int h, l, n;
    logic [63:0] exp_d, act_d, exp_r, act_r;
    h = b ? H1 : H0;
    l = b ? L1 : L0;
    n = h + l + 1;
    exp_d = '0; act_d = '0; exp_r = '0; act_r = '0;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL send_ready_before: got %b want 1", ready_out);
    end
    code_in = b;
    code_in_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      act_d[k] = dout;
      act_r[k] = ready_out;
      exp_d[k] = (k < h);
      exp_r[k] = (k == h + l);
      code_in_valid = spam && (k < n - 1);
      code_in = 1'($urandom);
    end
    code_in_valid = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < n; k++) if (act_d[k]) hi_cnt++;
    checks++;
    if (act_d !== exp_d) begin
      errors++; $display("FAIL bit%0d_dout: got %h want %h", b, act_d, exp_d);
    end
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL bit%0d_ready: got %h want %h", b, act_r, exp_r);
    end
  endtask

  task automatic test_bit0();
    int hc;
    send_bit(1'b0, 1'b0, hc);
  endtask

  task automatic test_bit1_ignore();
    int hc;
    send_bit(1'b1, 1'b1, hc);
    step();
    checks++;
    if (dout !== 1'b0 || ready_out !== 1'b1) begin
      errors++; $display("FAIL ignore_extra_pulse: got dout=%b ready=%b want dout=0 ready=1", dout, ready_out);
    end
  endtask

  task automatic test_frame();
    logic [23:0] frame;
    logic [23:0] got;
    int hc;
    frame = 24'hA50F3C;
    got = '0;
    for (int i = 23; i >= 0; i--) begin
      send_bit(frame[i], 1'b0, hc);
      got = {got[22:0], (hc == H1)};
    end
    checks++;
    if (got !== frame) begin
      errors++; $display("FAIL frame_decode: got %h want %h", got, frame);
    end
    checks++;
    if (ready_out !== 1'b1) begin
      errors++; $display("FAIL frame_ready_end: got %b want 1", ready_out);
    end
  endtask

  task automatic test_latch_idle();
    int n;
    logic [63:0] exp_r, act_r, exp_s, act_s, act_d;
    n = R + 3;
    exp_r = '0; act_r = '0; exp_s = '0; act_s = '0; act_d = '0;
    latch_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      latch_in = 1'b0;
      act_r[k] = ready_out;
      act_s[k] = res_done_out;
      act_d[k] = dout;
      exp_r[k] = (k >= R + 1);
      exp_s[k] = (k == R + 1);
    end
    checks++;
    if (act_d !== 64'd0) begin
      errors++; $display("FAIL latch_dout: got %h want 0", act_d);
    end
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL latch_ready: got %h want %h", act_r, exp_r);
    end
    checks++;
    if (act_s !== exp_s) begin
      errors++; $display("FAIL latch_res_done: got %h want %h", act_s, exp_s);
    end
  endtask

  // Bit '1' and latch on the same edge, then a second latch requested mid-reset.
  task automatic test_latch_with_bit();
    int a, s, n;
    logic [63:0] exp_d, act_d, exp_r, act_r, exp_s, act_s;
    a = H1 + L1;
    s = a + R + 1;
    n = s + R + 3;
    exp_d = '0; act_d = '0; exp_r = '0; act_r = '0; exp_s = '0; act_s = '0;
    code_in = 1'b1;
    code_in_valid = 1'b1;
    latch_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      code_in_valid = 1'b0;
      latch_in = (k == a + 3);
      act_d[k] = dout;
      act_r[k] = ready_out;
      act_s[k] = res_done_out;
      exp_d[k] = (k < H1);
      exp_r[k] = (k >= s + R + 1);
      exp_s[k] = (k == s) || (k == s + R + 1);
    end
    checks++;
    if (act_d !== exp_d) begin
      errors++; $display("FAIL bitlatch_dout: got %h want %h", act_d, exp_d);
    end
    checks++;
    if (act_r !== exp_r) begin
      errors++; $display("FAIL bitlatch_ready: got %h want %h", act_r, exp_r);
    end
    checks++;
    if (act_s !== exp_s) begin
      errors++; $display("FAIL bitlatch_res_done: got %h want %h", act_s, exp_s);
    end
  endtask

  task automatic test_random();
    int hc, gap;
    logic b;
    for (int i = 0; i < 12; i++) begin
      b = 1'($urandom);
      send_bit(b, 1'($urandom), hc);
      checks++;
      if (hc != (b ? H1 : H0)) begin
        errors++; $display("FAIL rand_width[%0d]: got %0d want %0d", i, hc, (b ? H1 : H0));
      end
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step();
      if ($urandom_range(0, 3) == 0) test_latch_idle();
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] act_d, act_r, act_s;
    code_in = 1'b1;
    code_in_valid = 1'b1;
    step();
    code_in_valid = 1'b0;
    latch_in = 1'b1;
    step();
    latch_in = 1'b0;
    checks++;
    if (dout !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset_dout: got %b want 1", dout);
    end
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (dout !== 1'b0) begin
      errors++; $display("FAIL mid_async_dout: got %b want 0", dout);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      act_d[k] = dout;
      act_r[k] = ready_out;
      act_s[k] = res_done_out;
    end
    checks++;
    if (act_d !== 16'h0000) begin
      errors++; $display("FAIL mid_after_dout: got %h want 0000", act_d);
    end
    checks++;
    if (act_r !== 16'hFFFF) begin
      errors++; $display("FAIL mid_after_ready: got %h want ffff", act_r);
    end
    checks++;
    if (act_s !== 16'h0000) begin
      errors++; $display("FAIL mid_after_res_done: got %h want 0000", act_s);
    end
  endtask

  initial begin
    rst_n_in = 1'b0;
    code_in = 1'b0;
    code_in_valid = 1'b0;
    latch_in = 1'b0;
    test_reset();
    test_bit0();
    test_bit1_ignore();
    test_frame();
    test_latch_idle();
    test_latch_with_bit();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
